// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: decodes E0/F0 key sequences and keeps
// the lock LEDs in sync with an ED,mask command with ACK retry.
//
// Ports:
//   CLK50MHZ, RST              clock, sync active-high reset
//   scancode, scan_ready       received byte stream
//   cmd, cmd_trig              byte to send, one-cycle send request
//   key_code/ext/release/valid decoded key event strobe
//   leds                       {caps, num, scroll}
//   busy, err                  LED transaction active / abort pulse
module ps2_kbd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  input  logic [7:0] scancode,
  input  logic       scan_ready,
  output logic [7:0] cmd,
  output logic       cmd_trig,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  output logic [2:0] leds,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(MAX_RETRY + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [AW-1:0] A_MAX  = AW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, SEND_ED, WAIT_ACK1, SEND_MASK, WAIT_ACK2
  } state_t;

  state_t         state, state_d;
  logic [TW-1:0]  timer, timer_d;
  logic [AW-1:0]  att, att_d;
  logic [7:0]     cmd_d;
  logic           trig_d, err_d, take;
  logic           ext, brk, pending;
  logic [2:0]     pressed, pressed_d;
  logic [2:0]     lock_sel, toggle;

  logic is_fa, is_fe, is_aa, is_e0, is_f0, is_e1;
  logic in_wait, ack, nak, dec_en, is_key;
  logic lock_ev, set_pend;

  assign is_fa = scancode == 8'hFA;
  assign is_fe = scancode == 8'hFE;
  assign is_aa = scancode == 8'hAA;
  assign is_e0 = scancode == 8'hE0;
  assign is_f0 = scancode == 8'hF0;
  assign is_e1 = scancode == 8'hE1;

  assign in_wait = (state == WAIT_ACK1) ||
                   (state == WAIT_ACK2);
  assign ack = scan_ready & in_wait & is_fa;
  assign nak = scan_ready & in_wait & is_fe;

  // FA/FE never reach the decoder; outside a wait they are dropped
  assign dec_en = scan_ready & ~is_fa & ~is_fe & ~is_aa;
  assign is_key = dec_en & ~is_e0 & ~is_f0 & ~is_e1;

  always_comb begin
    lock_sel = 3'b000;
    unique case (1'b1)
      scancode == 8'h58: lock_sel = 3'b100;
      scancode == 8'h77: lock_sel = 3'b010;
      scancode == 8'h7E: lock_sel = 3'b001;
      default: ;
    endcase
  end

  assign lock_ev = is_key & ~ext & (|lock_sel);

  // pressed flag suppresses typematic repeats
  always_comb begin
    toggle    = 3'b000;
    pressed_d = pressed;
    if (lock_ev) begin
      if (brk) begin
        pressed_d = pressed & ~lock_sel;
      end else if ((pressed & lock_sel) == 3'b000) begin
        toggle    = lock_sel;
        pressed_d = pressed | lock_sel;
      end
    end
  end

  assign set_pend = (scan_ready & is_aa) | (|toggle);

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      pressed     <= 3'b000;
      leds        <= 3'b000;
      pending     <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= is_key;
      if (dec_en) begin
        unique case (1'b1)
          is_e0: ext <= 1'b1;
          is_f0: brk <= 1'b1;
          is_e1: ;
          default: begin
            key_code    <= scancode;
            key_ext     <= ext;
            key_release <= brk;
            ext         <= 1'b0;
            brk         <= 1'b0;
          end
        endcase
      end
      pressed <= pressed_d;
      leds    <= leds ^ toggle;
      // a new request wins over the one being consumed
      pending <= (pending & ~take) | set_pend;
    end
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    att_d   = att;
    cmd_d   = cmd;
    trig_d  = 1'b0;
    err_d   = 1'b0;
    take    = 1'b0;
    unique case (state)
      IDLE: begin
        att_d = '0;
        if (pending) begin
          take    = 1'b1;
          state_d = SEND_ED;
        end
      end
      SEND_ED: begin
        cmd_d   = 8'hED;
        trig_d  = 1'b1;
        timer_d = T_LOAD;
        state_d = WAIT_ACK1;
      end
      SEND_MASK: begin
        cmd_d   = {5'b00000, leds};
        trig_d  = 1'b1;
        timer_d = T_LOAD;
        state_d = WAIT_ACK2;
      end
      WAIT_ACK1, WAIT_ACK2: begin
        if (ack) begin
          att_d   = '0;
          state_d = (state == WAIT_ACK1) ? SEND_MASK : IDLE;
        end else if (nak || timer == '0) begin
          if ((att + AW'(1)) < A_MAX) begin
            att_d   = att + AW'(1);
            state_d = (state == WAIT_ACK1) ? SEND_ED : SEND_MASK;
          end else begin
            att_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      att      <= '0;
      cmd      <= 8'h00;
      cmd_trig <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      att      <= att_d;
      cmd      <= cmd_d;
      cmd_trig <= trig_d;
      err      <= err_d;
      busy     <= state_d != IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: directed key, LED, retry,
// timeout and reset sequences plus a randomized key stream.
module tb_ps2_kbd_ctrl;

  localparam int T = 50;

  logic       CLK50MHZ = 1'b0;
  logic       RST;
  logic [7:0] scancode;
  logic       scan_ready;
  logic [7:0] cmd;
  logic       cmd_trig;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic [2:0] leds;
  logic       busy;
  logic       err;

  ps2_kbd_ctrl #(
    .TIMEOUT_CYCLES(T),
    .MAX_RETRY(3)
  ) dut (
    .CLK50MHZ(CLK50MHZ),
    .RST(RST),
    .scancode(scancode),
    .scan_ready(scan_ready),
    .cmd(cmd),
    .cmd_trig(cmd_trig),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_release(key_release),
    .key_valid(key_valid),
    .leds(leds),
    .busy(busy),
    .err(err)
  );

  always #10 CLK50MHZ = ~CLK50MHZ;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int ntrig = 0;
  int nerr = 0;
  int trig_cyc[$];
  logic [7:0] trig_cmd[$];

  always @(negedge CLK50MHZ) begin
    cyc++;
    if (cmd_trig === 1'b1) begin
      ntrig++;
      trig_cyc.push_back(cyc);
      trig_cmd.push_back(cmd);
    end
    if (err === 1'b1) nerr++;
  end

  // reference: byte-stream semantics of the keyboard protocol
  logic       mext, mbrk;
  logic [2:0] mleds, mpr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK50MHZ);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scancode   = b;
    scan_ready = 1'b1;
    tick();
    scan_ready = 1'b0;
    scancode   = 8'h00;
  endtask

  task automatic model_reset();
    mext  = 1'b0;
    mbrk  = 1'b0;
    mleds = 3'b000;
    mpr   = 3'b000;
  endtask

  task automatic do_reset();
    RST        = 1'b1;
    scan_ready = 1'b0;
    scancode   = 8'h00;
    tick();
    tick();
    RST = 1'b0;
    model_reset();
  endtask

  task automatic send_chk(input logic [7:0] b);
    logic       ev, eext, erel;
    logic [2:0] sel;
    ev = 1'b0;
    sel = 3'b000;
    eext = mext;
    erel = mbrk;
    if (b == 8'hE0) mext = 1'b1;
    else if (b == 8'hF0) mbrk = 1'b1;
    else if (b != 8'hE1) ev = 1'b1;
    if (ev) begin
      if (!mext) begin
        if (b == 8'h58) sel = 3'b100;
        if (b == 8'h77) sel = 3'b010;
        if (b == 8'h7E) sel = 3'b001;
      end
      if (sel != 3'b000) begin
        if (mbrk) mpr = mpr & ~sel;
        else if ((mpr & sel) == 3'b000) begin
          mleds = mleds ^ sel;
          mpr   = mpr | sel;
        end
      end
      mext = 1'b0;
      mbrk = 1'b0;
    end
    send(b);
    check("key_valid", key_valid, ev);
    if (ev) begin
      check("key_code", key_code, b);
      check("key_ext", key_ext, eext);
      check("key_release", key_release, erel);
    end
    check("leds", leds, mleds);
  endtask

  task automatic wait_trig(input string tag, input logic [7:0] exp,
                           output int lat);
    lat = 0;
    while (cmd_trig !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_trig"}, cmd_trig, 1'b1);
    check({tag, "_cmd"}, cmd, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_cmd"}, cmd, 8'h00);
    check({tag, "_trig"}, cmd_trig, 1'b0);
    check({tag, "_code"}, key_code, 8'h00);
    check({tag, "_ext"}, key_ext, 1'b0);
    check({tag, "_rel"}, key_release, 1'b0);
    check({tag, "_kv"}, key_valid, 1'b0);
    check({tag, "_leds"}, leds, 3'b000);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    int lat, t0, e0, q0, k;
    int p;
    logic [7:0] c;

    RST = 1'b1;
    scan_ready = 1'b0;
    scancode = 8'h00;
    model_reset();
    repeat (3) tick();
    chk_reset_vals("rst");
    RST = 1'b0;
    tick();

    // decoder sequences
    t0 = ntrig;
    send_chk(8'h1C);
    send_chk(8'hF0); send_chk(8'h1C);
    send_chk(8'hE0); send_chk(8'h75);
    send_chk(8'hE0); send_chk(8'hF0); send_chk(8'h75);
    send_chk(8'hF0); send_chk(8'hE0); send_chk(8'h6B);
    send_chk(8'hE1); send_chk(8'h14);
    send_chk(8'hE0); send_chk(8'h58);
    send(8'hFA);
    check("fa_idle_kv", key_valid, 1'b0);
    send(8'hFE);
    check("fe_idle_kv", key_valid, 1'b0);
    repeat (10) tick();
    check("no_trig_dec", ntrig - t0, 0);

    // randomized non-lock key stream
    for (int i = 0; i < 60; i++) begin
      p = $urandom_range(0, 4);
      c = 8'($urandom_range(1, 127));
      if ((c == 8'h58 || c == 8'h77 || c == 8'h7E) &&
          !(p == 1 || p == 3 || p == 4)) c = 8'h1C;
      case (p)
        1: send_chk(8'hE0);
        2: send_chk(8'hF0);
        3: begin send_chk(8'hE0); send_chk(8'hF0); end
        4: begin send_chk(8'hF0); send_chk(8'hE0); end
        default: ;
      endcase
      send_chk(c);
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (10) tick();
    check("rand_no_trig", ntrig - t0, 0);

    // caps lock transaction
    e0 = nerr;
    send_chk(8'h58);
    wait_trig("caps_ed", 8'hED, lat);
    check("caps_lat", lat, 2);
    check("caps_busy", busy, 1'b1);
    send(8'hFA);
    wait_trig("caps_mask", 8'h04, lat);
    send(8'hFA);
    check("caps_busy_done", busy, 1'b0);
    check("caps_err", nerr - e0, 0);
    send_chk(8'hF0); send_chk(8'h58);

    // typematic suppression
    do_reset();
    t0 = ntrig;
    send_chk(8'h58); send_chk(8'h58); send_chk(8'h58);
    wait_trig("typ1_ed", 8'hED, lat);
    send(8'hFA);
    wait_trig("typ1_mask", 8'h04, lat);
    send(8'hFA);
    send_chk(8'hF0); send_chk(8'h58);
    send_chk(8'h58);
    wait_trig("typ2_ed", 8'hED, lat);
    send(8'hFA);
    wait_trig("typ2_mask", 8'h00, lat);
    send(8'hFA);
    repeat (20) tick();
    check("typ_trigs", ntrig - t0, 4);

    // AA requests a refresh without a key event
    do_reset();
    send(8'hAA);
    check("aa_kv", key_valid, 1'b0);
    wait_trig("aa_ed", 8'hED, lat);
    send(8'hFA);
    wait_trig("aa_mask", 8'h00, lat);
    send(8'hFA);

    // timeout and abort
    do_reset();
    t0 = ntrig;
    e0 = nerr;
    q0 = trig_cyc.size();
    send_chk(8'h77);
    k = 0;
    while (nerr == e0 && k < 400) begin
      tick();
      k++;
    end
    check("to_err_seen", nerr - e0, 1);
    check("to_trigs", ntrig - t0, 3);
    check("to_busy", busy, 1'b0);
    check("to_leds", leds, 3'b010);
    if (trig_cyc.size() >= q0 + 3) begin
      for (int j = 0; j < 3; j++)
        check("to_cmd", trig_cmd[q0 + j], 8'hED);
      for (int j = 1; j < 3; j++) begin
        k = trig_cyc[q0 + j] - trig_cyc[q0 + j - 1];
        check("to_gap", (k >= T && k <= T + 3), 1'b1);
      end
    end
    repeat (T + 10) tick();
    check("to_no_more", ntrig - t0, 3);

    // NAK on mask once
    do_reset();
    e0 = nerr;
    send_chk(8'h7E);
    wait_trig("nak_ed", 8'hED, lat);
    send(8'hFA);
    wait_trig("nak_mask1", 8'h01, lat);
    send(8'hFE);
    wait_trig("nak_mask2", 8'h01, lat);
    send(8'hFA);
    check("nak_busy", busy, 1'b0);
    repeat (5) tick();
    check("nak_err", nerr - e0, 0);

    // lock during transaction, then reset in WAIT_ACK2
    do_reset();
    send_chk(8'h58);
    wait_trig("mid_ed1", 8'hED, lat);
    send_chk(8'h7E);
    check("mid_busy", busy, 1'b1);
    send(8'hFA);
    wait_trig("mid_mask1", 8'h05, lat);
    send(8'hFA);
    wait_trig("mid_ed2", 8'hED, lat);
    send(8'hFA);
    wait_trig("mid_mask2", 8'h05, lat);
    RST = 1'b1;
    tick();
    chk_reset_vals("midrst");
    RST = 1'b0;
    model_reset();
    t0 = ntrig;
    repeat (3 * T) tick();
    check("midrst_no_trig", ntrig - t0, 0);
    check("midrst_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Keyboard-level controller on the host side of the PS/2 command/receive stage.
- Consumes its received-byte stream (scancode, scan_ready) and decodes make/break/extended sequences into single key events.
- Tracks Caps/Num/Scroll lock state and drives that stage's command inputs (cmd, cmd_trig) to send the LED update sequence ED, mask, with ACK checking, timeout and retry.

Parameters:
- TIMEOUT_CYCLES, 1000000, cycles to wait for an ACK byte after cmd_trig (20 ms at 50 MHz).
- MAX_RETRY, 3, transmit attempts per command byte before abort.

Ports:
- CLK50MHZ input 1: system clock.
- RST input 1: synchronous, active-high reset.
- scancode input 8: received byte from the PS/2 stage; valid when scan_ready=1.
- scan_ready input 1: one-cycle strobe per received byte.
- cmd output 8: byte to transmit; held stable from cmd_trig until the transaction leaves the wait state.
- cmd_trig output 1: one-cycle pulse requesting transmission of cmd.
- key_code output 8: decoded key scan code, prefixes stripped.
- key_ext output 1: key was E0-prefixed.
- key_release output 1: key was F0-prefixed (break).
- key_valid output 1: one-cycle strobe; key_* valid this cycle.
- leds output 3: current lock state; bit0 Scroll, bit1 Num, bit2 Caps.
- busy output 1: LED transaction in progress.
- err output 1: one-cycle pulse on transaction abort.

Behaviour:
- Reset: cmd=00, cmd_trig=0, key_code=00, key_ext=0, key_release=0, key_valid=0, leds=000, busy=0, err=0. Decoder flags cleared, pressed-lock flags cleared, FSM in IDLE.
- Byte routing:
  - While the command FSM is in WAIT_ACK1 or WAIT_ACK2, bytes FA and FE go to the FSM.
  - All other bytes go to the decoder.
  - FA/FE received outside a wait state are dropped.
  - AA (self-test pass) is dropped and sets pending.
- Decoder:
  - E0 sets ext. F0 sets brk. E1 is dropped.
  - Any other byte produces key_valid at scan_ready+1 with key_code=byte, key_ext=ext, key_release=brk; ext and brk then clear.
  - F0 followed by E0 is accepted (flag order is irrelevant).
- Lock keys (non-extended only): 58 Caps, 77 Num, 7E Scroll.
  - On make: if the pressed flag is clear, toggle the leds bit (in the same cycle key_valid is driven), set the pressed flag, and set pending.
  - On break: clear the pressed flag.
  - Typematic repeats therefore never toggle.
- Command FSM states: IDLE, SEND_ED, WAIT_ACK1, SEND_MASK, WAIT_ACK2.
  - IDLE: if pending, clear pending, go to SEND_ED, busy=1.
  - SEND_ED: cmd=ED, cmd_trig pulse, load timer to TIMEOUT_CYCLES, go to WAIT_ACK1.
  - WAIT_ACK1:
    - FA: attempts reset, go to SEND_MASK.
    - FE or timer reaching 0: increment attempts; if attempts<MAX_RETRY go to SEND_ED, else err pulse, go to IDLE.
  - SEND_MASK: cmd={5'b0,leds} sampled now, cmd_trig pulse, load timer, go to WAIT_ACK2.
  - WAIT_ACK2: same as WAIT_ACK1, with retry target SEND_MASK; FA goes to IDLE.
  - busy=0 whenever the FSM is in IDLE.
- Latency: lock make byte at cycle N gives leds update and key_valid at N+1, and with the FSM idle, cmd_trig(ED) at N+3.
- Lock toggle during a transaction: leds update immediately and pending is set. The current transaction finishes, then a new one runs with the latest mask.
- Simultaneous timeout expiry and FA: FA wins.
- Timer width is clog2(TIMEOUT_CYCLES+1).
- RST mid-transaction: immediate return to reset values; no further cmd_trig until a new lock event.

Test Plan:
- Bytes 1C; then F0,1C; then E0,75; then E0,F0,75 -> four key_valid pulses: (1C,ext0,rel0), (1C,0,1), (75,1,0), (75,1,1). No pulse on any prefix byte.
- Caps make 58 -> leds=100, busy=1, cmd_trig with cmd=ED. Reply FA -> cmd_trig with cmd=04. Reply FA -> busy=0, err=0.
- 58,58,58 (typematic), then F0,58, then 58 -> only two toggles: leds 100 then 000. Exactly two ED/mask transactions.
- TIMEOUT_CYCLES=50, MAX_RETRY=3, Num make 77 with no replies -> three cmd_trig(ED) pulses about 51 cycles apart, then one err pulse, busy=0, leds=010.
- Reply FE to the mask byte once, then FA -> mask resent once, transaction completes without err.
- Scroll make 7E during WAIT_ACK1 of a Caps transaction -> leds=101. After the Caps transaction completes, a second ED is sent followed by mask 05. RST asserted in WAIT_ACK2 -> all outputs at reset values the next cycle.
